// File: rtl/spi_command_decoder.sv
// spi_command_decoder
//   Turns the byte stream from the SPI slave front end into writes to the
//   video pipeline settings registers. Each packet is an opcode byte followed
//   by a fixed-length, big-endian payload. A register group changes only when
//   its whole packet has arrived.
//
//   Handshake: a byte is accepted on every cycle where byte_ready is high.
//   There is no back-pressure. spi_active low marks a packet boundary. On a
//   cycle where both are active, the byte is processed first and the boundary
//   is applied afterwards.
//
// Ports
//   clk, rst      system clock, asynchronous active-high reset
//   spi_active    transaction in progress; low aborts any partial packet
//   byte_in       received byte, valid while byte_ready is high
//   byte_ready    one-cycle strobe, one byte per pulse
//   blend_mode    overlay/blend mode        (SET_MODE   0x01, 1 byte)
//   offset_x/y    signed foreground offsets (SET_OFFSET 0x02, 4 bytes)
//   alpha         foreground alpha          (SET_ALPHA  0x03, 1 byte)
//   chroma_key    RGB565 transparency key   (SET_KEY    0x04, 2 bytes)
//   cmd_done      one-cycle pulse per committed packet
//   err_count     saturating count of rejected packets
module spi_command_decoder #(
  parameter int OFFSET_WIDTH = 12
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           spi_active,
  input  logic [7:0]                     byte_in,
  input  logic                           byte_ready,
  output logic [2:0]                     blend_mode,
  output logic signed [OFFSET_WIDTH-1:0] offset_x,
  output logic signed [OFFSET_WIDTH-1:0] offset_y,
  output logic [7:0]                     alpha,
  output logic [15:0]                    chroma_key,
  output logic                           cmd_done,
  output logic [7:0]                     err_count
);

  localparam logic [7:0] OP_SET_MODE   = 8'h01;
  localparam logic [7:0] OP_SET_OFFSET = 8'h02;
  localparam logic [7:0] OP_SET_ALPHA  = 8'h03;
  localparam logic [7:0] OP_SET_KEY    = 8'h04;

  typedef enum logic [1:0] {
    S_OPCODE  = 2'd0,
    S_PAYLOAD = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  opcode;
  logic [2:0]  remaining;
  logic [31:0] shadow;

  // Decode of the incoming byte as a possible opcode.
  logic [2:0]  op_len;
  logic        op_known;
  // Shadow contents including the byte being received this cycle; a commit
  // uses this value so the last byte lands in the same edge as the commit.
  logic [31:0] shadow_next;
  logic        last_byte;
  logic        opcode_byte;
  logic        err_inc;

  always_comb begin
    op_len   = 3'd0;
    op_known = 1'b0;
    case (byte_in)
      OP_SET_MODE:   begin op_len = 3'd1; op_known = 1'b1; end
      OP_SET_OFFSET: begin op_len = 3'd4; op_known = 1'b1; end
      OP_SET_ALPHA:  begin op_len = 3'd1; op_known = 1'b1; end
      OP_SET_KEY:    begin op_len = 3'd2; op_known = 1'b1; end
      default:       begin op_len = 3'd0; op_known = 1'b0; end
    endcase
  end

  always_comb begin
    shadow_next = {shadow[23:0], byte_in};
    opcode_byte = byte_ready && (state == S_OPCODE);
    last_byte   = byte_ready && (state == S_PAYLOAD) && (remaining == 3'd1);
    // A packet is rejected either by an unknown opcode, or by the boundary
    // arriving while a packet is still incomplete after this cycle's byte
    // (including an opcode that arrived on the very cycle spi_active fell).
    err_inc = (opcode_byte && !op_known) ||
              (!spi_active && (((state == S_PAYLOAD) && !last_byte) ||
                               (opcode_byte && op_known)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_OPCODE;
      opcode     <= 8'h00;
      remaining  <= 3'd0;
      shadow     <= 32'h0;
      blend_mode <= 3'd0;
      offset_x   <= '0;
      offset_y   <= '0;
      alpha      <= 8'hFF;
      chroma_key <= 16'h0000;
      cmd_done   <= 1'b0;
      err_count  <= 8'h00;
    end else begin
      cmd_done <= 1'b0;

      if (err_inc && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end

      if (byte_ready) begin
        case (state)
          S_OPCODE: begin
            if (op_known) begin
              opcode    <= byte_in;
              remaining <= op_len;
              shadow    <= 32'h0;
              state     <= S_PAYLOAD;
            end else begin
              state <= S_DISCARD;
            end
          end
          S_PAYLOAD: begin
            shadow    <= shadow_next;
            remaining <= remaining - 3'd1;
            if (remaining == 3'd1) begin
              cmd_done <= 1'b1;
              state    <= S_OPCODE;
              case (opcode)
                OP_SET_MODE:   blend_mode <= shadow_next[2:0];
                OP_SET_OFFSET: begin
                  offset_x <= shadow_next[16 +: OFFSET_WIDTH];
                  offset_y <= shadow_next[0  +: OFFSET_WIDTH];
                end
                OP_SET_ALPHA:  alpha      <= shadow_next[7:0];
                OP_SET_KEY:    chroma_key <= shadow_next[15:0];
                default:       ;
              endcase
            end
          end
          default: ;  // S_DISCARD: wait for the packet boundary
        endcase
      end

      // Boundary takes priority over whatever the byte did to the parser.
      if (!spi_active) begin
        state     <= S_OPCODE;
        remaining <= 3'd0;
        shadow    <= 32'h0;
      end
    end
  end

endmodule
